// File: rtl/stream2mig_wr_pkg.sv
// Shared definitions for the stream-to-MIG frame writer: MIG command codes,
// stream type codes (mirroring dtypes.v), FSM encoding and burst sizing helper.
package stream2mig_wr_pkg;

    localparam logic [2:0] CMD_WRITE = 3'd0;
    localparam logic [2:0] CMD_READ  = 3'd1;
    localparam logic [2:0] CMD_IDLE  = 3'd5;

    // Stream type codes; pixel codes are any value with a bit in the pixel mask.
    localparam int DTYPE_WIDTH = 4;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 4'h1;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 4'h2;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER      = 4'h3;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK  = 4'hC;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DROP   = 3'd4
    } state_t;

    function automatic int burst_bytes(input int burst_len, input int port_width);
        return burst_len * port_width / 8;
    endfunction

endpackage

// File: rtl/stream2mig_desc_fifo.sv
// Single-clock {addr,len} descriptor queue with full/empty flags and a
// synchronous clear; head is read combinationally from the storage registers.
module stream2mig_desc_fifo #(
    parameter int ADDR_WIDTH = 30,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [ADDR_WIDTH-1:0] push_len,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH-1:0] head_addr,
    output logic [ADDR_WIDTH-1:0] head_len
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_len  [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW:0]           count;
    logic                  do_push;
    logic                  do_pop;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign do_pop    = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push   = push && (!full || do_pop);
    assign head_addr = mem_addr[rd_ptr];
    assign head_len  = mem_len[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr[i] <= '0;
                mem_len[i]  <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem_addr[wr_ptr] <= push_addr;
                mem_len[wr_ptr]  <= push_len;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/stream2mig_wr.sv
// Stream-to-MIG frame writer: packs stream beats into port words, bursts them to
// a DRAM ring and commits {base,len} descriptors. Optional STREAM2MIG_WR_DROP_COUNT_EN.
module stream2mig_wr
    import stream2mig_wr_pkg::*;
#(
    parameter int ADDR_WIDTH  = 30,
    parameter int DATAI_WIDTH = 16,
    parameter int PORT_WIDTH  = 32,
    parameter int BURST_LEN   = 16,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   dvi,
    input  logic [DTYPE_WIDTH-1:0] dtypei,
    input  logic [DATAI_WIDTH-1:0] datai,
    input  logic [ADDR_WIDTH-1:0]  ring_base,
    input  logic [ADDR_WIDTH-1:0]  ring_bytes,
    input  logic [ADDR_WIDTH-1:0]  max_frame_bytes,
    output logic                   p_wr_en,
    output logic [PORT_WIDTH-1:0]  p_wr_data,
    output logic                   p_cmd_en,
    output logic [2:0]             p_cmd_instr,
    output logic [5:0]             p_cmd_bl,
    output logic [ADDR_WIDTH-1:0]  p_cmd_byte_addr,
    input  logic                   p_cmd_full,
    output logic                   frame_valid,
    output logic [ADDR_WIDTH-1:0]  frame_addr,
    output logic [ADDR_WIDTH-1:0]  frame_len,
    input  logic                   frame_rd,
    output logic                   busy
`ifdef STREAM2MIG_WR_DROP_COUNT_EN
    ,
    output logic [15:0]            drop_count
`endif
);

    localparam int PACK   = PORT_WIDTH / DATAI_WIDTH;
    localparam int PCNT_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [PCNT_W-1:0]     PCNT_LAST = PCNT_W'(PACK - 1);
    localparam logic [ADDR_WIDTH-1:0] BB_A      = ADDR_WIDTH'(burst_bytes(BURST_LEN, PORT_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] BEAT_A    = ADDR_WIDTH'(DATAI_WIDTH / 8);
    localparam logic [6:0]            BL7       = 7'(BURST_LEN);
    localparam logic [6:0]            FIFO_CAP  = 7'd64;

    state_t                 state, state_nxt;
    logic [ADDR_WIDTH-1:0]  next_base, cur, waddr, fbytes;
    logic                   nb_valid, ovf, abort;
    logic [PORT_WIDTH-1:0]  pack_word, pack_cur;
    logic [PCNT_W-1:0]      pcnt;
    logic [6:0]             wcnt, wcnt_nxt, cmd_words;
    logic [5:0]             cmd_bl;

    logic                   frame_start, frame_end, is_data;
    logic [ADDR_WIDTH-1:0]  base_now, base_sel, len_c;
    logic                   q_full, q_empty, q_push, q_clear;
    logic                   start_frame, take_beat, beat_ovf, word_done, pad_word, emit;
    logic                   wr_go, wr_lost, full_go, res_go, cmd_go, flush_done;

    assign p_cmd_instr = CMD_WRITE;
    assign busy        = (state != ST_IDLE);
    assign frame_valid = !q_empty;

    assign frame_start = dvi && (dtypei == DTYPE_FRAME_START);
    assign frame_end   = dvi && (dtypei == DTYPE_FRAME_END);
    assign is_data     = dvi && (((dtypei & DTYPE_PIXEL_MASK) != '0) || (dtypei == DTYPE_HEADER));

    // next_base is only meaningful after the first commit; until then use ring_base.
    assign base_now = nb_valid ? next_base : ring_base;
    assign base_sel = (base_now + max_frame_bytes > ring_base + ring_bytes) ? ring_base : base_now;
    assign len_c    = waddr - cur;

    assign start_frame = (state == ST_IDLE) && enable && frame_start && !q_full;
    assign take_beat   = (state == ST_WRITE) && enable && is_data && (fbytes + BEAT_A <= max_frame_bytes);
    assign beat_ovf    = (state == ST_WRITE) && enable && is_data && !(fbytes + BEAT_A <= max_frame_bytes);
    assign word_done   = take_beat && (pcnt == PCNT_LAST);
    assign pad_word    = (state == ST_FLUSH) && (pcnt != '0);
    assign emit        = word_done || pad_word;

    assign wcnt_nxt = wcnt + {6'd0, p_wr_en} - (p_cmd_en ? ({1'b0, p_cmd_bl} + 7'd1) : 7'd0);
    assign wr_go    = emit && (wcnt_nxt < FIFO_CAP);
    assign wr_lost  = emit && !(wcnt_nxt < FIFO_CAP);

    assign full_go    = (state == ST_WRITE) && (wcnt >= BL7) && !p_cmd_full && !p_cmd_en;
    assign res_go     = (state == ST_FLUSH) && (pcnt == '0) && (wcnt != '0)
                        && !p_cmd_full && !p_cmd_en && !p_wr_en;
    assign cmd_go     = full_go || res_go;
    // Residual commands are capped at one burst so each command maps to one slot.
    assign cmd_words  = full_go ? BL7 : ((wcnt > BL7) ? BL7 : wcnt);
    assign cmd_bl     = 6'(cmd_words - 7'd1);
    assign flush_done = (state == ST_FLUSH) && (pcnt == '0) && !p_wr_en && (wcnt == '0) && !p_cmd_en;

    assign q_push  = (state == ST_COMMIT) && !ovf;
    assign q_clear = (flush_done && abort) || ((state == ST_DROP) && !enable);

    always_comb begin
        pack_cur = pack_word;
        if (take_beat)
            pack_cur[int'(pcnt)*DATAI_WIDTH +: DATAI_WIDTH] = datai;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (enable && frame_start) state_nxt = q_full ? ST_DROP : ST_WRITE;
            ST_WRITE:  if (!enable || frame_end) state_nxt = ST_FLUSH;
            ST_FLUSH:  if (flush_done) state_nxt = (abort || !enable) ? ST_IDLE : ST_COMMIT;
            ST_COMMIT: state_nxt = ST_IDLE;
            ST_DROP:   if (!enable || frame_end) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            next_base       <= '0;
            nb_valid        <= 1'b0;
            cur             <= '0;
            waddr           <= '0;
            fbytes          <= '0;
            ovf             <= 1'b0;
            abort           <= 1'b0;
            pack_word       <= '0;
            pcnt            <= '0;
            wcnt            <= '0;
            p_wr_en         <= 1'b0;
            p_wr_data       <= '0;
            p_cmd_en        <= 1'b0;
            p_cmd_bl        <= '0;
            p_cmd_byte_addr <= '0;
        end else begin
            state    <= state_nxt;
            wcnt     <= wcnt_nxt;
            p_wr_en  <= wr_go;
            p_cmd_en <= cmd_go;
            if (wr_go)
                p_wr_data <= pack_cur;
            if (cmd_go) begin
                p_cmd_bl        <= cmd_bl;
                p_cmd_byte_addr <= waddr;
                waddr           <= waddr + BB_A;
            end
            if (start_frame) begin
                cur       <= base_sel;
                waddr     <= base_sel;
                fbytes    <= '0;
                ovf       <= 1'b0;
                abort     <= 1'b0;
                pack_word <= '0;
                pcnt      <= '0;
            end
            if (take_beat) begin
                fbytes    <= fbytes + BEAT_A;
                pack_word <= pack_cur;
                pcnt      <= pcnt + 1'b1;
            end
            if (emit) begin
                pack_word <= '0;
                pcnt      <= '0;
            end
            if (beat_ovf || wr_lost)
                ovf <= 1'b1;
            if (((state == ST_WRITE) || (state == ST_FLUSH)) && !enable)
                abort <= 1'b1;
            if (q_push) begin
                next_base <= cur + len_c;
                nb_valid  <= 1'b1;
            end
        end
    end

`ifdef STREAM2MIG_WR_DROP_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_count <= '0;
        else if (((state == ST_IDLE && enable && frame_start && q_full) ||
                  (state == ST_COMMIT && ovf)) && (drop_count != 16'hFFFF))
            drop_count <= drop_count + 16'd1;
    end
`endif

    stream2mig_desc_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (QUEUE_DEPTH)
    ) u_desc_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (q_clear),
        .push      (q_push),
        .push_addr (cur),
        .push_len  (len_c),
        .pop       (frame_rd),
        .full      (q_full),
        .empty     (q_empty),
        .head_addr (frame_addr),
        .head_len  (frame_len)
    );

endmodule

// File: tb/tb_stream2mig_wr.sv
// Directed bench for stream2mig_wr: table of single frames plus hand-written
// sequences for queue-full drop, ring wrap, MIG-full overflow and enable abort.
`timescale 1ns/1ps
module tb_stream2mig_wr;
    import stream2mig_wr_pkg::*;

    localparam int AW = 30;

    logic                   clk = 1'b0;
    logic                   reset, enable, dvi, p_cmd_full, frame_rd;
    logic [DTYPE_WIDTH-1:0] dtypei;
    logic [15:0]            datai;
    logic [AW-1:0]          ring_base, ring_bytes, max_frame_bytes;
    logic                   p_wr_en, p_cmd_en, frame_valid, busy;
    logic [31:0]            p_wr_data;
    logic [2:0]             p_cmd_instr;
    logic [5:0]             p_cmd_bl;
    logic [AW-1:0]          p_cmd_byte_addr, frame_addr, frame_len;
`ifdef STREAM2MIG_WR_DROP_COUNT_EN
    logic [15:0]            drop_count;
`endif

    stream2mig_wr dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .dvi             (dvi),
        .dtypei          (dtypei),
        .datai           (datai),
        .ring_base       (ring_base),
        .ring_bytes      (ring_bytes),
        .max_frame_bytes (max_frame_bytes),
        .p_wr_en         (p_wr_en),
        .p_wr_data       (p_wr_data),
        .p_cmd_en        (p_cmd_en),
        .p_cmd_instr     (p_cmd_instr),
        .p_cmd_bl        (p_cmd_bl),
        .p_cmd_byte_addr (p_cmd_byte_addr),
        .p_cmd_full      (p_cmd_full),
        .frame_valid     (frame_valid),
        .frame_addr      (frame_addr),
        .frame_len       (frame_len),
        .frame_rd        (frame_rd),
        .busy            (busy)
`ifdef STREAM2MIG_WR_DROP_COUNT_EN
        ,
        .drop_count      (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Port-side monitor, sampled on the falling edge.
    int            wr_cnt = 0;
    int            cmd_cnt = 0;
    int            cons_err = 0;
    logic          prev_cmd = 1'b0;
    logic [31:0]   last_wdata = '0;
    logic [AW-1:0] cmd_addr_log [1024];
    logic [5:0]    cmd_bl_log   [1024];

    always @(negedge clk) begin
        if (p_wr_en) begin
            wr_cnt++;
            last_wdata = p_wr_data;
        end
        if (p_cmd_en) begin
            if (prev_cmd) cons_err++;
            cmd_addr_log[cmd_cnt % 1024] = p_cmd_byte_addr;
            cmd_bl_log[cmd_cnt % 1024]   = p_cmd_bl;
            cmd_cnt++;
        end
        prev_cmd = p_cmd_en;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic beat(input logic [DTYPE_WIDTH-1:0] t, input logic [15:0] d);
        @(posedge clk); #1;
        dvi = 1'b1; dtypei = t; datai = d;
    endtask

    task automatic idle_in();
        @(posedge clk); #1;
        dvi = 1'b0; dtypei = '0; datai = '0;
    endtask

    task automatic send_frame(input int npix);
        beat(DTYPE_FRAME_START, 16'h0);
        for (int i = 0; i < npix; i++) beat(4'h4, 16'hA000 + 16'(i));
        beat(DTYPE_FRAME_END, 16'h0);
        idle_in();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, n);
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic pop();
        @(posedge clk); #1 frame_rd = 1'b1;
        @(posedge clk); #1 frame_rd = 1'b0;
    endtask

    task automatic do_reset(input logic [AW-1:0] base, input logic [AW-1:0] bytes, input logic [AW-1:0] maxb);
        ring_base = base; ring_bytes = bytes; max_frame_bytes = maxb;
        reset = 1'b1; enable = 1'b1; p_cmd_full = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        int            npix;
        logic [AW-1:0] addr;
        logic [AW-1:0] len;
        int            words;
        int            cmds;
        logic [5:0]    last_bl;
        logic [31:0]   last_data;
    } vec_t;

    vec_t vt [4];

    initial begin
        int w0, c0;
        logic [AW-1:0] wrap_exp [3];

        vt[0] = '{64, 30'h1000, 30'h80, 32, 2, 6'd15, 32'hA03FA03E};
        vt[1] = '{21, 30'h1080, 30'h40, 11, 1, 6'd10, 32'h0000A014};
        vt[2] = '{ 2, 30'h10C0, 30'h40,  1, 1, 6'd0,  32'hA001A000};
        vt[3] = '{33, 30'h1100, 30'h80, 17, 2, 6'd0,  32'h0000A020};

        dvi = 1'b0; dtypei = '0; datai = '0; frame_rd = 1'b0;
        do_reset(30'h1000, 30'h10000, 30'h400);

        check("rst p_wr_en",     64'(p_wr_en), 64'd0);
        check("rst p_cmd_en",    64'(p_cmd_en), 64'd0);
        check("rst p_cmd_instr", 64'(p_cmd_instr), 64'd0);
        check("rst p_cmd_bl",    64'(p_cmd_bl), 64'd0);
        check("rst frame_valid", 64'(frame_valid), 64'd0);
        check("rst frame_addr",  64'(frame_addr), 64'd0);
        check("rst busy",        64'(busy), 64'd0);

        for (int v = 0; v < 4; v++) begin
            w0 = wr_cnt; c0 = cmd_cnt;
            send_frame(vt[v].npix);
            wait_idle("vec idle");
            check($sformatf("vec%0d words", v), 64'(wr_cnt - w0), 64'(vt[v].words));
            check($sformatf("vec%0d cmds", v), 64'(cmd_cnt - c0), 64'(vt[v].cmds));
            check($sformatf("vec%0d first cmd addr", v), 64'(cmd_addr_log[c0 % 1024]), 64'(vt[v].addr));
            check($sformatf("vec%0d last cmd addr", v), 64'(cmd_addr_log[(cmd_cnt - 1) % 1024]),
                  64'(vt[v].addr + 30'((vt[v].cmds - 1) * 64)));
            check($sformatf("vec%0d last bl", v), 64'(cmd_bl_log[(cmd_cnt - 1) % 1024]), 64'(vt[v].last_bl));
            check($sformatf("vec%0d last data", v), 64'(last_wdata), 64'(vt[v].last_data));
            check($sformatf("vec%0d frame_valid", v), 64'(frame_valid), 64'd1);
            check($sformatf("vec%0d frame_addr", v), 64'(frame_addr), 64'(vt[v].addr));
            check($sformatf("vec%0d frame_len", v), 64'(frame_len), 64'(vt[v].len));
            pop();
            check($sformatf("vec%0d popped", v), 64'(frame_valid), 64'd0);
        end

        // Queue full: four frames unread, fifth dropped, sixth lands after the fourth.
        do_reset(30'h1000, 30'h10000, 30'h100);
        for (int f = 0; f < 4; f++) begin
            send_frame(4);
            wait_idle("qfull idle");
        end
        check("qfull head addr", 64'(frame_addr), 64'h1000);
        w0 = wr_cnt;
        send_frame(4);
        wait_idle("drop idle");
        check("drop no writes", 64'(wr_cnt - w0), 64'd0);
        check("drop busy", 64'(busy), 64'd0);
`ifdef STREAM2MIG_WR_DROP_COUNT_EN
        check("drop_count one", 64'(drop_count), 64'd1);
`endif
        pop();
        check("qfull head after pop", 64'(frame_addr), 64'h1040);
        send_frame(4);
        wait_idle("sixth idle");
        pop(); pop(); pop();
        check("sixth valid", 64'(frame_valid), 64'd1);
        check("sixth addr", 64'(frame_addr), 64'h1100);
        check("sixth len", 64'(frame_len), 64'h40);

        // Ring wrap with slot reservation.
        do_reset(30'h0, 30'h200, 30'h100);
        wrap_exp[0] = 30'h0; wrap_exp[1] = 30'h100; wrap_exp[2] = 30'h0;
        for (int f = 0; f < 3; f++) begin
            send_frame(128);
            wait_idle("wrap idle");
            check($sformatf("wrap%0d addr", f), 64'(frame_addr), 64'(wrap_exp[f]));
            check($sformatf("wrap%0d len", f), 64'(frame_len), 64'h100);
            pop();
        end

        // MIG command port stalled: FIFO overflows, frame discarded, base unchanged.
        do_reset(30'h1000, 30'h10000, 30'h400);
        send_frame(4);
        wait_idle("pre-ovf idle");
        pop();
        p_cmd_full = 1'b1;
        w0 = wr_cnt;
        send_frame(200);
        repeat (10) @(negedge clk);
        check("ovf stalled busy", 64'(busy), 64'd1);
        p_cmd_full = 1'b0;
        wait_idle("ovf idle");
        check("ovf words accepted", 64'(wr_cnt - w0), 64'd64);
        check("ovf no descriptor", 64'(frame_valid), 64'd0);
`ifdef STREAM2MIG_WR_DROP_COUNT_EN
        check("ovf drop_count", 64'(drop_count), 64'd1);
`endif
        send_frame(2);
        wait_idle("post-ovf idle");
        check("post-ovf base", 64'(frame_addr), 64'h1040);
        pop();

        // Enable dropped mid-frame with five words queued at the MIG port.
        do_reset(30'h1000, 30'h10000, 30'h400);
        send_frame(4);
        wait_idle("pre-abort idle");
        check("pre-abort valid", 64'(frame_valid), 64'd1);
        c0 = cmd_cnt;
        beat(DTYPE_FRAME_START, 16'h0);
        for (int i = 0; i < 10; i++) beat(4'h4, 16'hB000 + 16'(i));
        idle_in();
        repeat (4) @(posedge clk);
        #1 enable = 1'b0;
        wait_idle("abort idle");
        check("abort cmds", 64'(cmd_cnt - c0), 64'd1);
        check("abort residual bl", 64'(cmd_bl_log[(cmd_cnt - 1) % 1024]), 64'd4);
        check("abort busy", 64'(busy), 64'd0);
        check("abort queue empty", 64'(frame_valid), 64'd0);
        enable = 1'b1;

        check("no back-to-back p_cmd_en", 64'(cons_err), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/stream2mig_wr.md
# stream2mig_wr

Parametrised single-clock stream-to-MIG frame writer. Packs a `DATAI_WIDTH` pixel/header stream into `PORT_WIDTH` MIG write-port words and issues bursts to the DRAM ring buffer. Each completed frame is committed as a `{base address, length}` descriptor into a small queue consumed by the read-side engine. Frames are dropped whole when the queue or the MIG write FIFO cannot take them.

## Interface
- `ADDR_WIDTH`, 30, MIG byte-address width
- `DATAI_WIDTH`, 16, stream data width (8/16/32); must divide `PORT_WIDTH`
- `PORT_WIDTH`, 32, MIG port data width (32/64/128)
- `BURST_LEN`, 16, words per full burst (≤64); `BURST_BYTES = BURST_LEN*PORT_WIDTH/8`
- `QUEUE_DEPTH`, 4, committed-frame descriptor slots (power of 2)
- `clk` in 1: single clock; stream and MIG port share it
- `reset` in 1: asynchronous, active-high
- `enable` in 1: block enable; low aborts and flushes
- `dvi` in 1: stream data valid
- `dtypei` in `DTYPE_WIDTH`: stream type; `dtypes.v` codes
- `datai` in `DATAI_WIDTH`: stream data
- `ring_base` in `ADDR_WIDTH`: ring start; `BURST_BYTES` aligned
- `ring_bytes` in `ADDR_WIDTH`: ring size
- `max_frame_bytes` in `ADDR_WIDTH`: slot reservation per frame
- `p_wr_en` out 1, `p_wr_data` out `PORT_WIDTH`: MIG write data
- `p_cmd_en` out 1, `p_cmd_instr` out 3 (constant 0, write), `p_cmd_bl` out 6, `p_cmd_byte_addr` out `ADDR_WIDTH`
- `p_cmd_full` in 1
- `frame_valid` out 1, `frame_addr` out `ADDR_WIDTH`, `frame_len` out `ADDR_WIDTH`: queue head
- `frame_rd` in 1: pop queue head when `frame_valid`
- `busy` out 1: high in any state other than IDLE

## Operation
- States:
  - IDLE → on `dvi && FRAME_START`: if queue full → DROP; else select base → WRITE.
  - WRITE → on `FRAME_END` → FLUSH.
  - FLUSH → COMMIT once partial word is written and tracked count is 0.
  - COMMIT → IDLE after one cycle.
  - DROP → IDLE on `FRAME_END`.
- Base select: `cur = next_base`; if `cur + max_frame_bytes > ring_base + ring_bytes`, then `cur = ring_base`. `next_base` resets to `ring_base`.
- Written data: `dvi` with `dtypei & DTYPE_PIXEL_MASK` nonzero or `DTYPE_HEADER`. Packed LSB-first, `PACK = PORT_WIDTH/DATAI_WIDTH` beats per word.
- Frame byte count: bytes beyond `max_frame_bytes` are discarded and set sticky `ovf`.
- Tracked MIG FIFO count `wcnt` (7b):
  - `+1` per `p_wr_en`
  - `-(p_cmd_bl+1)` per `p_cmd_en`
  - both updates apply in the same cycle.
- MIG FIFO full: a word arriving when `wcnt==64` is discarded and sets `ovf`.
- WRITE bursts: `p_cmd_bl=BURST_LEN-1` when `wcnt>=BURST_LEN && !p_cmd_full && !p_cmd_en`. Address advances by `BURST_BYTES` after each command.
- FLUSH:
  - A partial word is zero-padded and written.
  - Then a residual burst `p_cmd_bl=wcnt-1` is issued when `wcnt>0 && !p_cmd_full && !p_cmd_en && !p_wr_en`.
- COMMIT:
  - Pushes `{cur, len}` only if `!ovf`, with `len` rounded up to `BURST_BYTES`.
  - `next_base = cur + len`.
  - With `ovf`, pushes nothing and `next_base` is unchanged.
- `enable` low in WRITE/FLUSH:
  - Goes to FLUSH to drain the MIG FIFO with no commit.
  - Then IDLE; queue is emptied.
  - Further stream input is ignored until `enable` rises.
- Simultaneous push and `frame_rd`: both take effect; occupancy is unchanged.

## Timing
- Reset values:
  - All outputs 0, except `p_cmd_instr`=0 (constant).
  - State IDLE, `wcnt`=0, queue empty.
- `p_wr_en`/`p_wr_data` are registered, asserted the cycle after the `dvi` that completes a word.
- `p_cmd_en` is a one-cycle pulse, never in consecutive cycles. `p_cmd_bl`/`p_cmd_byte_addr` are stable while it is high.
- `frame_valid` rises the cycle after COMMIT. Head data changes the cycle after `frame_rd`.
- `FRAME_START` in any state other than IDLE is ignored. `FRAME_END` in IDLE is ignored.

## Configuration
- `STREAM2MIG_WR_DROP_COUNT_EN`:
  - Defined: adds output `drop_count` (16b, saturating, reset 0). It increments once per dropped frame (DROP entry, or COMMIT with `ovf`).
  - Undefined: port absent; behaviour otherwise identical.

## Structure
- Shared package holds:
  - MIG command codes (`CMD_WRITE=0`, `CMD_READ=1`, `CMD_IDLE=5`)
  - state encoding
  - `BURST_BYTES` function
- `dtypes.v` supplies the stream type codes.
- Sub-module `stream2mig_desc_fifo`: single-clock descriptor FIFO `{addr,len}`, depth `QUEUE_DEPTH`, with full/empty flags.

## Test plan
- 16b→32b, one 64-pixel frame at `ring_base=0x1000` → one burst `bl=15` at 0x1000, then a second burst at 0x1040. Descriptor `{0x1000, 0x80}`.
- Frame of 21 pixels → 11 words; padding word high half is 0; residual `bl=10`; `frame_len=0x40`.
- Queue full (4 frames unread), fifth frame → DROP, no `p_wr_en`, `drop_count=1`. After a `frame_rd`, the sixth frame commits at the correct next base.
- `ring_bytes=0x200`, `max_frame_bytes=0x100`, three 0x100-byte frames → bases 0x0, 0x100, then wraps to 0x0.
- Hold `p_cmd_full` during a 200-pixel frame → `ovf`, no descriptor pushed, `next_base` unchanged.
- Drop `enable` mid-frame with `wcnt=5` → residual `bl=4` issued, no descriptor, `busy` low afterwards, queue empty.
